// File: rtl/tim_pscr_pkg.sv
// Shared types and helpers for the timer prescaler tick generator.
// Optional build macro: TIM_PSCR_ODD_DIV_EN (accept odd divisors >= 3 as-is).
package tim_pscr_pkg;

  localparam int unsigned TIM_PSCR_MIN_DIV   = 2;
  localparam int unsigned TIM_PSCR_DIV_WIDTH = 20;

  typedef enum logic {
    TIM_PSCR_RUN,
    TIM_PSCR_SYNC
  } tim_pscr_state_e;

  // Clamp small divisors to the minimum and, unless odd divisors are enabled,
  // force the value even so the output clock keeps an exact 50% duty.
  // Operates on a 32-bit container; callers truncate to their own width, which
  // is safe because neither the clamp nor the LSB clear depends on width.
  function automatic logic [31:0] tim_pscr_sanitise(input logic [31:0] div);
    logic [31:0] r;
    if (div < 32'(TIM_PSCR_MIN_DIV)) begin
      r = 32'(TIM_PSCR_MIN_DIV);
    end else begin
`ifdef TIM_PSCR_ODD_DIV_EN
      r = div;
`else
      r = {div[31:1], 1'b0};
`endif
    end
    return r;
  endfunction

endpackage

// File: rtl/tim_pscr_tick_gen.sv
// Programmable prescaler: divides clk_i by a handshaken divisor, producing a
// registered divided clock, a terminal-count tick and a done/stable flag.
// Divisor changes are deferred to a period boundary so no period is truncated.
// Optional build macro: TIM_PSCR_ODD_DIV_EN (see tim_pscr_pkg).
module tim_pscr_tick_gen
  import tim_pscr_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = TIM_PSCR_DIV_WIDTH,
  parameter int unsigned DEF_DIV   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic                 div_done_o,
  output logic                 clk_o,
  output logic                 tick_o
);

  tim_pscr_state_e      state_q;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;
  logic                 ready_q, done_q;
  logic                 term;
  logic                 accept;

  assign pend_d = DIV_WIDTH'(tim_pscr_sanitise(32'(div_i)));
  assign term   = (cnt_q == div_q - 1'b1);
  // ready_q is only ever high in RUN, so this also implies the RUN state.
  assign accept = div_valid_i && ready_q;

  // Next divisor/count, and the output levels that go with them, so clk_o and
  // tick_o stay cycle-aligned with the counter value they describe.
  always_comb begin
    div_d = div_q;
    if (accept && term)
      div_d = pend_d;
    else if (state_q == TIM_PSCR_SYNC && term)
      div_d = pend_q;
    cnt_d  = term ? '0 : cnt_q + 1'b1;
    clk_d  = (cnt_d >= (div_d >> 1));
    tick_d = (cnt_d == div_d - 1'b1);
  end

  // Counter, output flops and the RUN/SYNC handshake FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TIM_PSCR_RUN;
      div_q   <= DIV_WIDTH'(DEF_DIV);
      pend_q  <= DIV_WIDTH'(DEF_DIV);
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b1;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      case (state_q)
        TIM_PSCR_RUN: begin
          if (accept) begin
            pend_q <= pend_d;
            // A request landing on the terminal cycle is applied directly;
            // anything earlier waits out the current period in SYNC.
            if (!term) begin
              state_q <= TIM_PSCR_SYNC;
              ready_q <= 1'b0;
              done_q  <= 1'b0;
            end
          end
        end
        TIM_PSCR_SYNC: begin
          if (term) begin
            state_q <= TIM_PSCR_RUN;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= TIM_PSCR_RUN;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign div_ready_o = ready_q;
  assign div_done_o  = done_q;
  assign clk_o       = clk_q;
  assign tick_o      = tick_q;

endmodule

// File: tb/tb_tim_pscr_tick_gen.sv
// Self-checking bench for tim_pscr_tick_gen: a period-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_tim_pscr_tick_gen;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [19:0] div_i = '0;
  logic        div_valid_i = 1'b0;
  logic        div_ready_o, div_done_o, clk_o, tick_o;

  int checks = 0;
  int failures = 0;

  tim_pscr_tick_gen #(.DIV_WIDTH(20), .DEF_DIV(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .div_i(div_i), .div_valid_i(div_valid_i),
    .div_ready_o(div_ready_o), .div_done_o(div_done_o),
    .clk_o(clk_o), .tick_o(tick_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int san(input int d);
    if (d < 2) return 2;
`ifdef TIM_PSCR_ODD_DIV_EN
    return d;
`else
    return (d / 2) * 2;
`endif
  endfunction

  // Reference model: position within the current period, the active divisor,
  // and at most one divisor waiting for the next period boundary.
  int m_div = 2;
  int m_pos = 0;
  int m_pend[$];
  bit m_ok = 1'b0;

  always @(posedge clk_i) begin : model
    bit last;
    if (rst_i) begin
      m_div = 2; m_pos = 0; m_pend.delete(); m_ok = 1'b1;
    end else if (m_ok) begin
      last = (m_pos == m_div - 1);
      if (div_valid_i && m_pend.size() == 0) begin
        if (last) m_div = san(int'(div_i));
        else      m_pend.push_back(san(int'(div_i)));
      end else if (last && m_pend.size() != 0) begin
        m_div = m_pend.pop_front();
      end
      m_pos = last ? 0 : m_pos + 1;
    end
  end

  always @(negedge clk_i) begin
    if (m_ok) begin
      chk("clk_o",  int'(clk_o),  int'(m_pos >= m_div / 2));
      chk("tick_o", int'(tick_o), int'(m_pos == m_div - 1));
      chk("ready",  int'(div_ready_o), int'(m_pend.size() == 0));
      chk("done",   int'(div_done_o),  int'(m_pend.size() == 0));
    end
  end

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!div_done_o && n < 200) begin cyc(); n++; end
    chk("done_timeout", int'(div_done_o), 1);
  endtask

  // From any point: find a tick, then count samples until the next tick.
  task automatic measure(output int per, output int low);
    int n = 0;
    per = 0; low = 0;
    while (!tick_o && n < 200) begin cyc(); n++; end
    chk("tick_seen", int'(tick_o), 1);
    n = 0;
    do begin
      cyc(); per++;
      if (!clk_o) low++;
    end while (!tick_o && per < 200);
  endtask

  task automatic load(input int d);
    div_i = 20'(d); div_valid_i = 1'b1;
    cyc();
    div_valid_i = 1'b0;
    wait_done();
  endtask

  initial begin : stim
    int per, low, hi;
    bit dropped;
    bit [3:0] seq;
    rst_i = 1'b1;
    repeat (2) cyc();
    rst_i = 1'b0;

    // reset state
    chk("rst_clk", int'(clk_o), 0);
    chk("rst_tick", int'(tick_o), 0);
    chk("rst_ready", int'(div_ready_o), 1);
    chk("rst_done", int'(div_done_o), 1);

    // idle divide-by-2: clk 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      seq[i] = clk_o;
      if (i < 3) cyc();
    end
    chk("idle_seq", int'(seq), 4'b1010);
    cyc(); // cnt back to 0

    // load 8 mid-period
    div_i = 20'd8; div_valid_i = 1'b1;
    cyc();
    div_valid_i = 1'b0;
    chk("l8_ready_drop", int'(div_ready_o), 0);
    chk("l8_done_drop", int'(div_done_o), 0);
    chk("l8_old_tick", int'(tick_o), 1);
    cyc();
    chk("l8_done_back", int'(div_done_o), 1);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (clk_o) hi++;
      chk("l8_clk_shape", int'(clk_o), int'(i >= 4));
      chk("l8_tick_pos", int'(tick_o), int'(i == 7));
      if (i < 7) cyc();
    end
    chk("l8_high_cnt", hi, 4);

    // load 4 exactly on the terminal cycle: applied next cycle, done stays 1
    div_i = 20'd4; div_valid_i = 1'b1;
    cyc();
    div_valid_i = 1'b0;
    dropped = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!div_done_o) dropped = 1'b1;
      chk("l4_tick_pos", int'(tick_o), int'(i == 3));
      if (i < 3) cyc();
    end
    chk("l4_done_held", int'(dropped), 0);

    // sanitising
    load(0);  measure(per, low);
    chk("san0_per", per, 2); chk("san0_low", low, 1);
    load(1);  measure(per, low);
    chk("san1_per", per, 2); chk("san1_low", low, 1);
    load(7);  measure(per, low);
`ifdef TIM_PSCR_ODD_DIV_EN
    chk("san7_per", per, 7); chk("san7_low", low, 3);
`else
    chk("san7_per", per, 6); chk("san7_low", low, 3);
`endif

    // request while in SYNC is dropped
    cyc(); // cnt 0
    div_i = 20'd10; div_valid_i = 1'b1;
    cyc();
    chk("sync_ready", int'(div_ready_o), 0);
    div_i = 20'd16;
    cyc(); cyc();
    div_valid_i = 1'b0;
    wait_done();
    measure(per, low);
    chk("sync_ign_per", per, 10);
    chk("sync_ign_low", low, 5);

    // reset in SYNC discards the pending divisor
    cyc(); // cnt 0
    div_i = 20'd12; div_valid_i = 1'b1;
    cyc();
    div_valid_i = 1'b0;
    chk("rs_in_sync", int'(div_done_o), 0);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    chk("rs_clk", int'(clk_o), 0);
    chk("rs_tick", int'(tick_o), 0);
    chk("rs_ready", int'(div_ready_o), 1);
    chk("rs_done", int'(div_done_o), 1);
    measure(per, low);
    chk("rs_per", per, 2);
    repeat (12) cyc();
    chk("rs_pend_lost", int'(div_done_o), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
